mux_serial_ctrl: RTL
====================

MUX_SERIAL_CTRL -- requirements
Module: mux_serial_ctrl

Interface
REQ-001 Parameter: DIV_WIDTH, default 4, width of the per-bit hold-time counter and of the rate input.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
REQ-004 start  input  1  request to begin a transfer; sampled on rising clock edge.
REQ-005 data_in  input  7  word to serialize; captured on an accepted start.
REQ-006 last_sel  input  3  index of final bit to send; captured on an accepted start.
REQ-007 rate  input  DIV_WIDTH  hold cycles per bit minus one; captured on an accepted start.
REQ-008 sel  output  3  current mux select index, registered.
REQ-009 serial_out  output  1  selected bit of the captured word (7:1 select of data_reg by sel).
REQ-010 busy  output  1  high while a transfer is in progress.
REQ-011 done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: busy=0, sel=0; start=1 SHALL capture data_in into data_reg, last_sel into last_reg, rate into rate_reg, load hold counter with rate, and go to SHIFT next cycle.
REQ-014 last_sel=7 SHALL be captured as 6 (index 7 is not a valid mux input).
REQ-015 SHIFT: busy=1; sel SHALL hold each index for exactly rate_reg+1 cycles, starting at 0.
REQ-016 Hold counter SHALL decrement each SHIFT cycle; at 0 with sel<last_reg, sel increments by 1 and the counter reloads rate_reg.
REQ-017 At counter 0 with sel==last_reg, FSM SHALL go to DONE; sel holds its value for that transition.
REQ-018 DONE: lasts exactly one cycle, done=1, busy=0, then IDLE with sel=0.
REQ-019 Transfer length SHALL be (last_reg+1)*(rate_reg+1) SHIFT cycles; start-to-done latency = that + 1 cycle.
REQ-020 serial_out SHALL equal data_reg[sel] combinationally from registered sel/data_reg; it SHALL be 0 in IDLE (data_reg cleared to 0 on reset, and sel=0 selects data_reg[0], which holds its captured value; serial_out SHALL be gated to 0 when busy=0).
REQ-021 start asserted during SHIFT or DONE SHALL be ignored; no re-capture, no restart.
REQ-022 start held high continuously SHALL begin a new transfer on the first IDLE cycle after DONE (back-to-back, one IDLE cycle gap).
REQ-023 data_in, last_sel, rate changes during SHIFT SHALL NOT affect the transfer in progress.
REQ-024 rate=0 SHALL yield one cycle per bit; rate=all-ones SHALL yield 2^DIV_WIDTH cycles per bit.
REQ-025 sel SHALL never exceed 6.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force state=IDLE, sel=0, busy=0, done=0, serial_out=0, data_reg=0, last_reg=0, rate_reg=0, counter=0.
REQ-027 reset asserted mid-SHIFT SHALL abort the transfer with no done pulse; operation resumes with the first start after reset deasserts.

Verification
REQ-028 Basic: reset, data_in=7'b1010011, last_sel=6, rate=0, pulse start -> serial_out sequence 1,1,0,0,1,0,1 over sel 0..6, done one cycle after sel=6 ends, busy high 7 cycles.
REQ-029 Rate: data_in=7'b0000101, last_sel=2, rate=3 -> each of sel 0,1,2 held 4 cycles, serial_out 1,0,1, busy 12 cycles, single done pulse.
REQ-030 Clamp/short: last_sel=7 -> sel stops at 6; last_sel=0, rate=0 -> busy 1 cycle, sel stays 0, done next cycle.
REQ-031 Ignored start: start pulses and data_in changes during SHIFT -> output sequence and timing identical to undisturbed run.
REQ-032 Back-to-back: start held high, two words -> second transfer begins exactly one IDLE cycle after done; both sequences correct.
REQ-033 Reset mid-op: assert reset at sel=3 of a 7-bit transfer -> all outputs 0 within same cycle, no done pulse; a fresh start afterwards runs a full correct transfer.

Source files
------------

// File: rtl/mux_serial_ctrl.sv
// mux_serial_ctrl: serializes a captured 7-bit word through a 7:1 mux.
// Each bit index is held for (rate+1) cycles, from index 0 up to the captured
// last index, followed by a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; sel parked at 0, serial_out gated low
// SHIFT | stepping sel through 0..last_q, rate_q+1 cycles per index
// DONE  | single-cycle completion pulse, then back to IDLE
module mux_serial_ctrl #(
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [6:0]           data_in_i,
  input  logic [2:0]           last_sel_i,
  input  logic [DIV_WIDTH-1:0] rate_i,
  output logic [2:0]           sel_o,
  output logic                 serial_out_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  state_t               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [6:0]           data_q, data_d;
  logic [2:0]           last_q, last_d;
  logic [DIV_WIDTH-1:0] rate_q, rate_d;
  logic [7:0]           data_ext;

  // State and datapath registers; reset clears everything so outputs drop at once.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= '0;
      rate_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      rate_q  <= rate_d;
    end
  end

  // Next-state logic: capture on start in IDLE, hold-counter driven stepping in SHIFT.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    rate_d  = rate_q;
    case (state_q)
      S_IDLE: begin
        sel_d = '0;
        if (start_i) begin
          data_d  = data_in_i;
          // Index 7 has no mux input behind it, so the last bit is clamped to 6.
          last_d  = (last_sel_i == 3'd7) ? 3'd6 : last_sel_i;
          rate_d  = rate_i;
          cnt_d   = rate_i;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (sel_q < last_q) begin
            sel_d = sel_q + 3'd1;
            cnt_d = rate_q;
          end else begin
            // sel keeps its final index through the DONE cycle.
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state; serial_out is forced low outside SHIFT.
  always_comb begin
    data_ext     = {1'b0, data_q};
    busy_o       = (state_q == S_SHIFT);
    done_o       = (state_q == S_DONE);
    sel_o        = sel_q;
    serial_out_o = busy_o & data_ext[sel_q];
  end

endmodule
